// File: rtl/pipeline_id_ex.sv
// pipeline_id_ex
// ---------------------------------------------------------------------------
// ID/EX pipeline register for the 16-bit, 16-register pipelined core, with
// load-use hazard detection, write-back-to-operand bypass and a saturating
// bubble counter.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   stall_in            global freeze: hold every EX register
//   flush               squash the instruction currently in ID
//   id_*                decoded instruction from ID (indices, operands,
//                       immediate, PC+2, control bundle)
//   wb_reg_write/dst/data  register-file write happening this cycle
//   ex_*                registered instruction presented to EX
//   hazard_stall        combinational: freeze PC and IF/ID (load-use)
//   halt_seen           sticky: a valid halt has entered EX
//   bubble_count        saturating count of inserted bubbles
//
// Handshake: ex_valid qualifies every ex_* field (a bubble has ex_valid = 0
// and all control zero). hazard_stall is the stage's "not ready" towards
// IF/ID: while it is high the ID instruction is not consumed and must be
// re-presented unchanged on the next cycle. stall_in is a "not ready" from
// downstream: while it is high nothing moves into or out of this stage.
// ---------------------------------------------------------------------------
module pipeline_id_ex (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic [3:0]  id_rd,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [15:0] id_rs_data,
  input  logic [15:0] id_rt_data,
  input  logic [15:0] id_imm,
  input  logic [15:0] id_pc_plus2,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        id_pc_to_reg,
  input  logic        id_halt,
  input  logic [2:0]  id_flag_en,
  input  logic        wb_reg_write,
  input  logic [3:0]  wb_dst,
  input  logic [15:0] wb_data,
  output logic        ex_valid,
  output logic [3:0]  ex_rs,
  output logic [3:0]  ex_rt,
  output logic [3:0]  ex_rd,
  output logic [15:0] ex_rs_data,
  output logic [15:0] ex_rt_data,
  output logic [15:0] ex_imm,
  output logic [15:0] ex_pc_plus2,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_pc_to_reg,
  output logic        ex_halt,
  output logic [2:0]  ex_flag_en,
  output logic        hazard_stall,
  output logic        halt_seen,
  output logic [15:0] bubble_count
);

  typedef struct packed {
    logic        valid;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [3:0]  rd;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
    logic [15:0] pc_plus2;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        pc_to_reg;
    logic        halt;
    logic [2:0]  flag_en;
  } ex_t;

  ex_t         ex_q, ex_d;
  logic        halt_seen_q, halt_seen_d;
  logic [15:0] bubble_count_q, bubble_count_d;

  logic load_use;
  logic wb_hit;
  logic count_inc;

  // Register 0 is hard-wired, so it never produces a hazard or a bypass.
  assign wb_hit = wb_reg_write && (wb_dst != 4'd0);

  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 4'd0) && id_valid &&
                    ((id_uses_rs && (id_rs == ex_q.rd)) ||
                     (id_uses_rt && (id_rt == ex_q.rd)));

  // Only a load-use that will actually become a bubble on this edge may
  // freeze the front end; stall, flush and halt all take precedence.
  assign hazard_stall = load_use && !stall_in && !flush && !halt_seen_q;

  always_comb begin
    ex_d        = ex_q;
    halt_seen_d = halt_seen_q;
    count_inc   = 1'b0;

    if (stall_in) begin
      // Frozen stage, but a register write landing now must still reach the
      // held operands or they would go stale while we wait.
      if (wb_hit && (wb_dst == ex_q.rs)) ex_d.rs_data = wb_data;
      if (wb_hit && (wb_dst == ex_q.rt)) ex_d.rt_data = wb_data;
    end else if (flush) begin
      ex_d      = '0;
      count_inc = 1'b1;
    end else if (halt_seen_q) begin
      // After a halt everything is a bubble; only real instructions count.
      ex_d      = '0;
      count_inc = id_valid;
    end else if (load_use) begin
      ex_d      = '0;
      count_inc = 1'b1;
    end else begin
      ex_d.valid      = id_valid;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.rd         = id_rd;
      ex_d.rs_data    = (wb_hit && (wb_dst == id_rs)) ? wb_data : id_rs_data;
      ex_d.rt_data    = (wb_hit && (wb_dst == id_rt)) ? wb_data : id_rt_data;
      ex_d.imm        = id_imm;
      ex_d.pc_plus2   = id_pc_plus2;
      ex_d.reg_write  = id_reg_write  && id_valid;
      ex_d.mem_read   = id_mem_read   && id_valid;
      ex_d.mem_write  = id_mem_write  && id_valid;
      ex_d.mem_to_reg = id_mem_to_reg && id_valid;
      ex_d.pc_to_reg  = id_pc_to_reg  && id_valid;
      ex_d.halt       = id_halt       && id_valid;
      ex_d.flag_en    = id_valid ? id_flag_en : 3'b000;
      if (id_valid && id_halt) halt_seen_d = 1'b1;
    end

    bubble_count_d = bubble_count_q;
    if (count_inc && (bubble_count_q != 16'hFFFF)) begin
      bubble_count_d = bubble_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q           <= '0;
      halt_seen_q    <= 1'b0;
      bubble_count_q <= 16'd0;
    end else begin
      ex_q           <= ex_d;
      halt_seen_q    <= halt_seen_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign ex_rs_data    = ex_q.rs_data;
  assign ex_rt_data    = ex_q.rt_data;
  assign ex_imm        = ex_q.imm;
  assign ex_pc_plus2   = ex_q.pc_plus2;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_pc_to_reg  = ex_q.pc_to_reg;
  assign ex_halt       = ex_q.halt;
  assign ex_flag_en    = ex_q.flag_en;
  assign halt_seen     = halt_seen_q;
  assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_pipeline_id_ex.sv
// Testbench for pipeline_id_ex: directed vectors, expected EX state pushed
// into a queue before each edge and popped/compared by a monitor after it.
module tb_pipeline_id_ex;

  localparam int W = 103;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        stall_in, flush, id_valid;
  logic [3:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt;
  logic [15:0] id_rs_data, id_rt_data, id_imm, id_pc_plus2;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_pc_to_reg, id_halt;
  logic [2:0]  id_flag_en;
  logic        wb_reg_write;
  logic [3:0]  wb_dst;
  logic [15:0] wb_data;
  logic        ex_valid;
  logic [3:0]  ex_rs, ex_rt, ex_rd;
  logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus2;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_pc_to_reg, ex_halt;
  logic [2:0]  ex_flag_en;
  logic        hazard_stall, halt_seen;
  logic [15:0] bubble_count;

  pipeline_id_ex dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc_plus2(id_pc_plus2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_pc_to_reg(id_pc_to_reg), .id_halt(id_halt),
    .id_flag_en(id_flag_en), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc_plus2(ex_pc_plus2),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_pc_to_reg(ex_pc_to_reg), .ex_halt(ex_halt),
    .ex_flag_en(ex_flag_en), .hazard_stall(hazard_stall), .halt_seen(halt_seen),
    .bubble_count(bubble_count)
  );

  // Observed registered state, same field order as mk().
  logic [W-1:0] act_vec;
  assign act_vec = {ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus2,
                    ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_pc_to_reg, ex_halt,
                    ex_flag_en, halt_seen, bubble_count};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                                      input logic [3:0] rd, input logic [15:0] rsd,
                                      input logic [15:0] rtd, input logic [15:0] imm,
                                      input logic [15:0] pc, input logic [5:0] ctrl,
                                      input logic [2:0] fl, input logic hs,
                                      input logic [15:0] cnt);
    return {v, rs, rt, rd, rsd, rtd, imm, pc, ctrl, fl, hs, cnt};
  endfunction

  function automatic logic [W-1:0] bubble(input logic hs, input logic [15:0] cnt);
    return mk(1'b0, 4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 16'd0, 6'd0, 3'd0, hs, cnt);
  endfunction

  // Monitor: one edge after each push the DUT presents the matching state.
  initial begin
    logic [W-1:0] e;
    string        n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, act_vec, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, pc_to_reg, halt}
  task automatic set_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] rd, input logic urs, input logic urt,
                        input logic [15:0] rsd, input logic [15:0] rtd, input logic [15:0] imm,
                        input logic [15:0] pc, input logic [5:0] ctrl, input logic [2:0] fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_pc_plus2 = pc;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_pc_to_reg, id_halt} = ctrl;
    id_flag_en = fl;
  endtask

  task automatic set_wb(input logic w, input logic [3:0] dst, input logic [15:0] data);
    wb_reg_write = w; wb_dst = dst; wb_data = data;
  endtask

  task automatic set_ctl(input logic st, input logic fl);
    stall_in = st; flush = fl;
  endtask

  // Check hazard_stall before the edge, queue the post-edge state, advance.
  task automatic step(input string nm, input logic exp_h, input logic [W-1:0] e);
    #1;
    check({nm, "_hazard"}, {{(W-1){1'b0}}, hazard_stall}, {{(W-1){1'b0}}, exp_h});
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  localparam logic [5:0] C_ALU = 6'b100000;
  localparam logic [5:0] C_LW  = 6'b110100;
  localparam logic [5:0] C_HLT = 6'b000001;

  initial begin
    logic [W-1:0] v;
    set_ctl(1'b0, 1'b0);
    set_wb(1'b0, 4'd0, 16'd0);
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 6'd0, 3'd0);

    repeat (2) @(posedge clk);
    #2;
    check("reset_state", act_vec, {W{1'b0}});
    rst = 1'b1;

    // Plain capture of ADD r4 = r2 + r3
    set_id(1'b1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 16'h1234, 16'h0011, 16'h0005, 16'h0002, C_ALU, 3'b111);
    #1;
    check("pre_capture_zero", act_vec, {W{1'b0}});
    step("capture_add", 1'b0, mk(1'b1, 4'd2, 4'd3, 4'd4, 16'h1234, 16'h0011, 16'h0005, 16'h0002, C_ALU, 3'b111, 1'b0, 16'd0));

    // LW r5 enters EX
    set_id(1'b1, 4'd1, 4'd0, 4'd5, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0004, 16'h0004, C_LW, 3'b000);
    step("capture_lw_r5", 1'b0, mk(1'b1, 4'd1, 4'd0, 4'd5, 16'h0100, 16'h0000, 16'h0004, 16'h0004, C_LW, 3'b000, 1'b0, 16'd0));

    // Dependent ADD: one bubble, then captured
    set_id(1'b1, 4'd5, 4'd6, 4'd7, 1'b1, 1'b1, 16'h0AAA, 16'h0BBB, 16'h0000, 16'h0006, C_ALU, 3'b111);
    step("load_use_bubble", 1'b1, bubble(1'b0, 16'd1));
    step("load_use_capture", 1'b0, mk(1'b1, 4'd5, 4'd6, 4'd7, 16'h0AAA, 16'h0BBB, 16'h0000, 16'h0006, C_ALU, 3'b111, 1'b0, 16'd1));

    // LW r0 then a reader of r0: no hazard
    set_id(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0000, 16'h0008, C_LW, 3'b000);
    step("capture_lw_r0", 1'b0, mk(1'b1, 4'd1, 4'd0, 4'd0, 16'h0200, 16'h0000, 16'h0000, 16'h0008, C_LW, 3'b000, 1'b0, 16'd1));
    set_id(1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h000A, C_ALU, 3'b000);
    step("r0_no_hazard", 1'b0, mk(1'b1, 4'd0, 4'd0, 4'd3, 16'h0000, 16'h0000, 16'h0000, 16'h000A, C_ALU, 3'b000, 1'b0, 16'd1));

    // WB bypass into captured rs
    set_id(1'b1, 4'd7, 4'd2, 4'd1, 1'b1, 1'b1, 16'h0000, 16'h2222, 16'h0003, 16'h000C, C_ALU, 3'b000);
    set_wb(1'b1, 4'd7, 16'hBEEF);
    step("bypass_capture_rs", 1'b0, mk(1'b1, 4'd7, 4'd2, 4'd1, 16'hBEEF, 16'h2222, 16'h0003, 16'h000C, C_ALU, 3'b000, 1'b0, 16'd1));

    // Write to r0 must not bypass
    set_id(1'b1, 4'd0, 4'd7, 4'd2, 1'b1, 1'b1, 16'h1111, 16'h3333, 16'h0000, 16'h000E, C_ALU, 3'b000);
    set_wb(1'b1, 4'd0, 16'hDEAD);
    step("no_bypass_r0", 1'b0, mk(1'b1, 4'd0, 4'd7, 4'd2, 16'h1111, 16'h3333, 16'h0000, 16'h000E, C_ALU, 3'b000, 1'b0, 16'd1));

    // Stall: held ex_rt = 7 picks up the write-back, everything else holds
    set_ctl(1'b1, 1'b0);
    set_id(1'b1, 4'd9, 4'd9, 4'd9, 1'b1, 1'b1, 16'h5555, 16'h6666, 16'h7777, 16'h8888, C_LW, 3'b101);
    set_wb(1'b1, 4'd7, 16'hCAFE);
    step("stall_bypass_rt", 1'b0, mk(1'b1, 4'd0, 4'd7, 4'd2, 16'h1111, 16'hCAFE, 16'h0000, 16'h000E, C_ALU, 3'b000, 1'b0, 16'd1));
    set_wb(1'b0, 4'd0, 16'd0);
    set_ctl(1'b0, 1'b0);

    // Flush beats load-use
    v = mk(1'b1, 4'd1, 4'd0, 4'd9, 16'h0010, 16'h0000, 16'h0020, 16'h0010, C_LW, 3'b000, 1'b0, 16'd1);
    set_id(1'b1, 4'd1, 4'd0, 4'd9, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0020, 16'h0010, C_LW, 3'b000);
    step("capture_lw_r9", 1'b0, v);
    set_id(1'b1, 4'd9, 4'd0, 4'd4, 1'b1, 1'b0, 16'h0444, 16'h0000, 16'h0000, 16'h0012, C_ALU, 3'b000);
    set_ctl(1'b0, 1'b1);
    step("flush_over_hazard", 1'b0, bubble(1'b0, 16'd2));
    set_ctl(1'b0, 1'b0);
    v = mk(1'b1, 4'd9, 4'd0, 4'd4, 16'h0444, 16'h0000, 16'h0000, 16'h0012, C_ALU, 3'b000, 1'b0, 16'd2);
    step("capture_after_flush", 1'b0, v);

    // Stall beats flush
    set_ctl(1'b1, 1'b1);
    set_id(1'b1, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 16'h9999, 16'h9999, 16'h9999, 16'h9999, C_ALU, 3'b111);
    step("stall_over_flush", 1'b0, v);
    set_ctl(1'b0, 1'b0);

    // Stall suppresses hazard_stall; hazard resolves after stall drops
    v = mk(1'b1, 4'd1, 4'd0, 4'd9, 16'h0010, 16'h0000, 16'h0020, 16'h0010, C_LW, 3'b000, 1'b0, 16'd2);
    set_id(1'b1, 4'd1, 4'd0, 4'd9, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0020, 16'h0010, C_LW, 3'b000);
    step("capture_lw_r9_b", 1'b0, v);
    set_id(1'b1, 4'd0, 4'd9, 4'd4, 1'b0, 1'b1, 16'h0000, 16'h0444, 16'h0000, 16'h0012, C_ALU, 3'b000);
    set_ctl(1'b1, 1'b0);
    step("stall_masks_hazard", 1'b0, v);
    set_ctl(1'b0, 1'b0);
    step("hazard_via_rt", 1'b1, bubble(1'b0, 16'd3));

    // Halt
    set_id(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0020, C_HLT, 3'b000);
    step("capture_halt", 1'b0, mk(1'b1, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0020, C_HLT, 3'b000, 1'b1, 16'd3));
    set_id(1'b1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 16'h1234, 16'h0011, 16'h0005, 16'h0022, C_ALU, 3'b111);
    step("post_halt_valid", 1'b0, bubble(1'b1, 16'd4));
    id_valid = 1'b0;
    step("post_halt_invalid", 1'b0, bubble(1'b1, 16'd4));

    // Saturation: count is 4, reaches 0xFFFF after 65531 more valid cycles
    id_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      if (i == 65530) step("count_reach_max", 1'b0, bubble(1'b1, 16'hFFFF));
      else if (i == 65535) step("count_saturated", 1'b0, bubble(1'b1, 16'hFFFF));
      else begin
        @(posedge clk);
        #2;
      end
    end

    // Asynchronous reset mid-cycle clears everything immediately
    #3;
    rst = 1'b0;
    #1;
    check("async_reset", act_vec, {W{1'b0}});
    check("async_reset_hazard", {{(W-1){1'b0}}, hazard_stall}, {W{1'b0}});
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Drain: every queued expectation must have been consumed
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
